// File: rtl/slc3_mem_responder.sv
// SLC-3 memory responder: answers MAR/MDR read and write strobes from the
// SLC-3 core with a fixed number of wait states and a one-cycle acknowledge.
// Address xFFFF is memory-mapped I/O: switches on read, hex display on write.
module slc3_mem_responder #(
    parameter int WAIT_CYCLES = 2,
    parameter int MEM_WORDS   = 256
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] ADDR,
    input  logic [15:0] Data_to_Mem,
    input  logic        OE,
    input  logic        WE,
    input  logic [15:0] SW,
    output logic [15:0] Data_from_Mem,
    output logic        Mem_Ready,
    output logic [15:0] Hex_Out
);

    localparam int          AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [2:0]  LAST_WAIT = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;
    localparam logic [16:0] MEM_LIMIT = 17'(MEM_WORDS);
    localparam logic [15:0] IO_ADDR   = 16'hFFFF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK,
        S_HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        is_write_q, is_write_d;
    logic        mem_ready_q, mem_ready_d;
    logic [15:0] rdata_q, rdata_d;
    logic [15:0] hex_q, hex_d;

    logic [15:0] mem [MEM_WORDS];

    logic          is_io;
    logic          in_range;
    logic [AW-1:0] mem_idx;
    logic          active_strobe;
    logic          commit_write;

    // Decode the latched address and pick the strobe that keeps the transaction alive
    always_comb begin
        is_io         = (addr_q == IO_ADDR);
        in_range      = ({1'b0, addr_q} < MEM_LIMIT);
        mem_idx       = addr_q[AW-1:0];
        active_strobe = is_write_q ? WE : OE;
        commit_write  = (state_q == S_ACK) && is_write_q && in_range && !is_io;
    end

    // Next-state and next-output logic for the handshake FSM
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        is_write_d  = is_write_q;
        mem_ready_d = 1'b0;
        rdata_d     = rdata_q;
        hex_d       = hex_q;

        case (state_q)
            S_IDLE: begin
                if (OE ^ WE) begin
                    addr_d     = ADDR;
                    wdata_d    = Data_to_Mem;
                    is_write_d = WE;
                    cnt_d      = 3'd0;
                    state_d    = (WAIT_CYCLES == 0) ? S_ACK : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!active_strobe) begin
                    state_d = S_IDLE;
                    cnt_d   = 3'd0;
                end else if (cnt_q == LAST_WAIT) begin
                    state_d = S_ACK;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_ACK: begin
                mem_ready_d = 1'b1;
                state_d     = S_HOLD;
                if (is_write_q) begin
                    rdata_d = wdata_q;
                    if (is_io) begin
                        hex_d = wdata_q;
                    end
                end else if (is_io) begin
                    rdata_d = SW;
                end else if (in_range) begin
                    rdata_d = mem[mem_idx];
                end else begin
                    rdata_d = 16'h0000;
                end
            end
            S_HOLD: begin
                if (!OE && !WE) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Register FSM state and all outputs; reset clears everything except memory
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 3'd0;
            addr_q      <= 16'h0000;
            wdata_q     <= 16'h0000;
            is_write_q  <= 1'b0;
            mem_ready_q <= 1'b0;
            rdata_q     <= 16'h0000;
            hex_q       <= 16'h0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            is_write_q  <= is_write_d;
            mem_ready_q <= mem_ready_d;
            rdata_q     <= rdata_d;
            hex_q       <= hex_d;
        end
    end

    // Memory array has no reset so its contents survive a Reset pulse
    always_ff @(posedge Clk) begin
        if (commit_write) begin
            mem[mem_idx] <= wdata_q;
        end
    end

    assign Data_from_Mem = rdata_q;
    assign Mem_Ready     = mem_ready_q;
    assign Hex_Out       = hex_q;

endmodule

// File: tb/tb_slc3_mem_responder.sv
// Directed bench for slc3_mem_responder: one instance with two wait states,
// one with zero wait states, driven from a vector table plus corner sequences.
module tb_slc3_mem_responder;

    typedef struct {
        logic        is_write;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] sw;
        logic [15:0] exp_data;
        logic [15:0] exp_hex;
        logic        chk_data;
    } vec_t;

    logic        Clk;
    logic        Reset;
    logic [15:0] ADDR;
    logic [15:0] Data_to_Mem;
    logic [15:0] SW;
    logic        OE, WE;
    logic        oe0, we0;
    logic [15:0] dfm, dfm0;
    logic [15:0] hex, hex0;
    logic        rdy, rdy0;

    int num_checks = 0;
    int num_errors = 0;

    vec_t vecs[14];

    slc3_mem_responder #(.WAIT_CYCLES(2), .MEM_WORDS(256)) dut (
        .Clk(Clk), .Reset(Reset), .ADDR(ADDR), .Data_to_Mem(Data_to_Mem),
        .OE(OE), .WE(WE), .SW(SW),
        .Data_from_Mem(dfm), .Mem_Ready(rdy), .Hex_Out(hex)
    );

    slc3_mem_responder #(.WAIT_CYCLES(0), .MEM_WORDS(256)) dut0 (
        .Clk(Clk), .Reset(Reset), .ADDR(ADDR), .Data_to_Mem(Data_to_Mem),
        .OE(oe0), .WE(we0), .SW(SW),
        .Data_from_Mem(dfm0), .Mem_Ready(rdy0), .Hex_Out(hex0)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check_output(input string name, input logic [15:0] actual,
                                input logic [15:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    function automatic logic cur_ready(input bit sel);
        return sel ? rdy0 : rdy;
    endfunction

    // Called at a falling edge; the next rising edge is the acceptance edge.
    // After acceptance ADDR/Data_to_Mem are scrambled and SW gets its final value.
    task automatic apply_stimulus(input vec_t v, input bit sel, input int exp_lat,
                                  input string tag);
        int k;
        ADDR        = v.addr;
        Data_to_Mem = v.wdata;
        SW          = ~v.sw;
        if (sel) begin
            oe0 = !v.is_write;
            we0 = v.is_write;
        end else begin
            OE = !v.is_write;
            WE = v.is_write;
        end
        @(posedge Clk);
        @(negedge Clk);
        ADDR        = v.addr ^ 16'h0F0F;
        Data_to_Mem = ~v.wdata;
        SW          = v.sw;
        k = 0;
        while (!cur_ready(sel) && k < 20) begin
            @(posedge Clk);
            @(negedge Clk);
            k++;
        end
        check_output({tag, " latency"}, 16'(k), 16'(exp_lat));
        if (v.chk_data) begin
            check_output({tag, " data"}, sel ? dfm0 : dfm, v.exp_data);
        end
        check_output({tag, " hex"}, sel ? hex0 : hex, v.exp_hex);
        OE  = 1'b0;
        WE  = 1'b0;
        oe0 = 1'b0;
        we0 = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        check_output({tag, " pulse width"}, {15'd0, cur_ready(sel)}, 16'h0000);
    endtask

    initial begin
        vec_t v;
        int   pulses;
        int   first_k;
        logic [15:0] data_at_ack;

        vecs[0]  = '{1'b1, 16'h0010, 16'h1234, 16'h0000, 16'h1234, 16'h0000, 1'b1};
        vecs[1]  = '{1'b0, 16'h0010, 16'h0000, 16'h0000, 16'h1234, 16'h0000, 1'b1};
        vecs[2]  = '{1'b1, 16'hFFFF, 16'hBEEF, 16'h0000, 16'hBEEF, 16'hBEEF, 1'b1};
        vecs[3]  = '{1'b0, 16'hFFFF, 16'h0000, 16'h00A5, 16'h00A5, 16'hBEEF, 1'b1};
        vecs[4]  = '{1'b1, 16'h0020, 16'hAAAA, 16'h0000, 16'hAAAA, 16'hBEEF, 1'b1};
        vecs[5]  = '{1'b1, 16'h0000, 16'h1111, 16'h0000, 16'h1111, 16'hBEEF, 1'b1};
        vecs[6]  = '{1'b1, 16'h00FF, 16'h2222, 16'h0000, 16'h2222, 16'hBEEF, 1'b1};
        vecs[7]  = '{1'b1, 16'h0100, 16'h7777, 16'h0000, 16'h0000, 16'hBEEF, 1'b0};
        vecs[8]  = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h1111, 16'hBEEF, 1'b1};
        vecs[9]  = '{1'b0, 16'h00FF, 16'h0000, 16'h0000, 16'h2222, 16'hBEEF, 1'b1};
        vecs[10] = '{1'b0, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'hBEEF, 1'b1};
        vecs[11] = '{1'b0, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'hBEEF, 1'b1};
        vecs[12] = '{1'b1, 16'h0030, 16'h4242, 16'h0000, 16'h4242, 16'hBEEF, 1'b1};
        vecs[13] = '{1'b0, 16'hFFFF, 16'h0000, 16'h5A5A, 16'h5A5A, 16'hBEEF, 1'b1};

        Reset = 1'b1;
        ADDR = 16'h0000; Data_to_Mem = 16'h0000; SW = 16'h0000;
        OE = 1'b0; WE = 1'b0; oe0 = 1'b0; we0 = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check_output("reset ready", {15'd0, rdy}, 16'h0000);
        check_output("reset data", dfm, 16'h0000);
        check_output("reset hex", hex, 16'h0000);
        check_output("reset ready0", {15'd0, rdy0}, 16'h0000);
        check_output("reset hex0", hex0, 16'h0000);
        Reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            apply_stimulus(vecs[i], 1'b0, 3, $sformatf("vec%0d", i));
        end

        // Both strobes high: must be ignored for as long as they stay high
        ADDR = 16'h0010; Data_to_Mem = 16'hDEAD; OE = 1'b1; WE = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge Clk);
            @(negedge Clk);
            check_output($sformatf("both high ready c%0d", i), {15'd0, rdy}, 16'h0000);
        end
        OE = 1'b0; WE = 1'b0;
        v = '{1'b0, 16'h0010, 16'h0000, 16'h0000, 16'h1234, 16'hBEEF, 1'b1};
        apply_stimulus(v, 1'b0, 3, "after both high");

        // Write strobe dropped after one wait cycle aborts the write
        ADDR = 16'h0020; Data_to_Mem = 16'h5555; WE = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        @(posedge Clk);
        @(negedge Clk);
        WE = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge Clk);
            @(negedge Clk);
            check_output($sformatf("abort ready c%0d", i), {15'd0, rdy}, 16'h0000);
        end
        v = '{1'b0, 16'h0020, 16'h0000, 16'h0000, 16'hAAAA, 16'hBEEF, 1'b1};
        apply_stimulus(v, 1'b0, 3, "after abort");

        // Reset in the middle of a write's wait states
        ADDR = 16'h0030; Data_to_Mem = 16'h9999; WE = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        check_output("midwait reset ready", {15'd0, rdy}, 16'h0000);
        check_output("midwait reset data", dfm, 16'h0000);
        check_output("midwait reset hex", hex, 16'h0000);
        WE = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        v = '{1'b0, 16'h0030, 16'h0000, 16'h0000, 16'h4242, 16'h0000, 1'b1};
        apply_stimulus(v, 1'b0, 3, "after reset");

        // Zero wait states: OE held four cycles gives exactly one pulse
        ADDR = 16'h0100; oe0 = 1'b1;
        @(posedge Clk);
        pulses = 0;
        first_k = 0;
        data_at_ack = 16'hFFFF;
        for (int i = 1; i <= 4; i++) begin
            @(posedge Clk);
            @(negedge Clk);
            if (rdy0) begin
                pulses++;
                if (first_k == 0) begin
                    first_k = i;
                    data_at_ack = dfm0;
                end
            end
        end
        check_output("wc0 pulse count", 16'(pulses), 16'd1);
        check_output("wc0 first pulse edge", 16'(first_k), 16'd1);
        check_output("wc0 out of range data", data_at_ack, 16'h0000);
        oe0 = 1'b0;
        @(posedge Clk);
        @(negedge Clk);

        v = '{1'b1, 16'h0005, 16'hCAFE, 16'h0000, 16'hCAFE, 16'h0000, 1'b1};
        apply_stimulus(v, 1'b1, 1, "wc0 write");
        v = '{1'b0, 16'h0005, 16'h0000, 16'h0000, 16'hCAFE, 16'h0000, 1'b1};
        apply_stimulus(v, 1'b1, 1, "wc0 read");
        v = '{1'b1, 16'hFFFF, 16'h1357, 16'h0000, 16'h1357, 16'h1357, 1'b1};
        apply_stimulus(v, 1'b1, 1, "wc0 io write");
        v = '{1'b0, 16'hFFFF, 16'h0000, 16'h0F0F, 16'h0F0F, 16'h1357, 1'b1};
        apply_stimulus(v, 1'b1, 1, "wc0 io read");

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
